// File: rtl/gf_pkg.sv
// Shared types and constants for the GF(2^N) matrix-vector datapath.
// Holds the FSM state encoding and the common reduction polynomials.
package gf_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam logic [8:0] GF8_AES_POLY = 9'h11B;
    localparam logic [4:0] GF4_POLY     = 5'h13;

endpackage

// File: rtl/gf_matvec_seq_if.sv
// Job/result handshake bundle for the sequential GF matrix-vector unit.
// The slave side is the multiplier; the master side is source plus consumer.
interface gf_matvec_seq_if #(
    parameter int N    = 8,
    parameter int ROWS = 4,
    parameter int COLS = 4
);
    logic [N:0]             p;
    logic                   in_valid;
    logic                   in_ready;
    logic [ROWS*COLS*N-1:0] a_flat;
    logic [COLS*N-1:0]      b_flat;
    logic                   accumulate;
    logic                   out_valid;
    logic                   out_ready;
    logic [ROWS*N-1:0]      s_flat;
    logic                   busy;

    modport master (
        output p, in_valid, a_flat, b_flat, accumulate, out_ready,
        input  in_ready, out_valid, s_flat, busy
    );

    modport slave (
        input  p, in_valid, a_flat, b_flat, accumulate, out_ready,
        output in_ready, out_valid, s_flat, busy
    );
endinterface

// File: rtl/gf_mult_comb.sv
// Combinational GF(2^N) multiply: carry-less product reduced modulo p.
// Reduction walks from degree 2N-2 down to N, MSB first.
module gf_mult_comb #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N:0]   p,
    output logic [N-1:0] s
);

    logic [2*N-2:0] prod;

    // carry-less product followed by polynomial reduction
    always_comb begin
        prod = '0;
        for (int i = 0; i < N; i++) begin
            if (b[i]) prod[i +: N] = prod[i +: N] ^ a;
        end
        for (int i = 2*N-2; i >= N; i--) begin
            if (prod[i]) prod[i-N +: N+1] = prod[i-N +: N+1] ^ p;
        end
        s = prod[N-1:0];
    end

endmodule

// File: rtl/gf_matvec_seq.sv
// Sequential GF(2^N) matrix-vector multiplier, one MAC per clock.
// s = A*b, or s = A*b + s_prev when the job requests accumulate.
module gf_matvec_seq
    import gf_pkg::*;
#(
    parameter int N    = 8,
    parameter int ROWS = 4,
    parameter int COLS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    gf_matvec_seq_if.slave     io
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    state_t                 state_q, state_d;
    logic [RW-1:0]          r_q, r_d;
    logic [CW-1:0]          c_q, c_d;
    logic [N-1:0]           acc_q, acc_d;
    logic [N:0]             p_q, p_d;
    logic [ROWS*COLS*N-1:0] a_q, a_d;
    logic [COLS*N-1:0]      b_q, b_d;
    logic                   accum_q, accum_d;
    logic [ROWS*N-1:0]      s_q, s_d;

    logic [N-1:0] a_el, b_el, prod, acc_nxt;

    assign a_el    = a_q[(int'(r_q)*COLS + int'(c_q))*N +: N];
    assign b_el    = b_q[int'(c_q)*N +: N];
    assign acc_nxt = acc_q ^ prod;

    gf_mult_comb #(.N(N)) u_mul (
        .a (a_el),
        .b (b_el),
        .p (p_q),
        .s (prod)
    );

    assign io.in_ready  = (state_q == ST_IDLE);
    assign io.out_valid = (state_q == ST_DONE);
    assign io.busy      = (state_q == ST_RUN);
    assign io.s_flat    = s_q;

    // next-state: job capture, MAC walk over rows/cols, result hand-off
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        acc_d   = acc_q;
        p_d     = p_q;
        a_d     = a_q;
        b_d     = b_q;
        accum_d = accum_q;
        s_d     = s_q;
        unique case (state_q)
            ST_IDLE: begin
                if (io.in_valid) begin
                    p_d     = io.p;
                    a_d     = io.a_flat;
                    b_d     = io.b_flat;
                    accum_d = io.accumulate;
                    r_d     = '0;
                    c_d     = '0;
                    acc_d   = io.accumulate ? s_q[N-1:0] : '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (c_q == CW'(COLS-1)) begin
                    s_d[int'(r_q)*N +: N] = acc_nxt;
                    c_d = '0;
                    if (r_q == RW'(ROWS-1)) begin
                        acc_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        r_d   = r_q + RW'(1);
                        acc_d = accum_q ? s_q[(int'(r_q)+1)*N +: N] : '0;
                    end
                end else begin
                    c_d   = c_q + CW'(1);
                    acc_d = acc_nxt;
                end
            end
            ST_DONE: begin
                if (io.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            c_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            accum_q <= 1'b0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            a_q     <= a_d;
            b_q     <= b_d;
            accum_q <= accum_d;
            s_q     <= s_d;
        end
    end

endmodule

// File: doc/gf_matvec_seq.md
Name: gf_matvec_seq

Overview:
- Sequential matrix-vector multiplier over GF(2^N): s = A·b (optionally s = A·b + s_prev), with a run-time reduction polynomial.
- Computes one GF multiply-accumulate per clock, so one multiplier replaces ROWS·COLS parallel multipliers.
- Valid/ready handshakes on input and output; it sits between a coefficient/vector source and a downstream consumer in the Galois-arithmetic datapath.

Parameters:
- N, 8, field degree (symbol width in bits); N ≥ 2.
- ROWS, 4, matrix rows (result length); ROWS ≥ 1.
- COLS, 4, matrix columns (vector length); COLS ≥ 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- p  in  N+1  reduction polynomial; p[N] must be 1. Sampled on accept.
- in_valid  in  1  job offered.
- in_ready  out  1  block can accept a job.
- a_flat  in  ROWS·COLS·N  matrix; element (r,c) is at [(r·COLS+c)·N +: N]. Sampled on accept.
- b_flat  in  COLS·N  vector; element c is at [c·N +: N]. Sampled on accept.
- accumulate  in  1  on accept: 1 adds the new product into the stored result, 0 overwrites it.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- s_flat  out  ROWS·N  result; element r is at [r·N +: N].
- busy  out  1  high in RUN.

Behaviour:
- Reset (rst_n=0 at an edge), effective in any state including mid-RUN:
  - state goes to IDLE; in_ready=1, out_valid=0, busy=0, s_flat=0.
  - row/column counters, accumulator and latched p/a/b are cleared; any in-flight job is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Accept = in_valid & in_ready at an edge: latch p, a_flat, b_flat and accumulate; set r=0, c=0.
  - Initialise acc to s[0] if accumulate=1, else to 0. Go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle: acc ← acc ⊕ gfmul(A[r][c], b[c]).
  - When c=COLS-1: write s[r] ← final acc, c←0, r←r+1, and reload acc with s[r+1] (accumulate=1) or 0.
  - After the MAC with r=ROWS-1, c=COLS-1, go to DONE.
  - in_valid is ignored during RUN.
- DONE:
  - out_valid=1; s_flat is stable and holds the result.
  - When out_ready=1 at an edge, go to IDLE and drop out_valid.
  - in_ready=0 in DONE: no same-cycle accept, so back-to-back jobs have a one-cycle IDLE bubble.
- Latency: out_valid rises exactly ROWS·COLS cycles after the accept edge.
- s_flat timing:
  - Updates row-by-row during RUN; it is valid only while out_valid=1.
  - It retains its value through IDLE, which is what makes accumulate mode work.
- gfmul(x,y) is the carry-less product of x and y (2N-1 bits) reduced modulo the latched p to N bits; the MSB-first reduction covers all degrees 2N-2 down to N.
- Addition is bitwise XOR. No width growth: all stored values are N bits.
- If p[N]=0, the result is undefined but the handshake timing is unchanged.
- ROWS=COLS=1: one RUN cycle, then DONE.
- Changes on p, a_flat, b_flat or accumulate after accept have no effect on the running job.

Decomposition:
- Package gf_pkg:
  - state typedef (IDLE/RUN/DONE);
  - polynomial constants (GF8_AES_POLY=9'h11B, GF4_POLY=5'h13).
- Sub-module gf_mult_comb #(N): purely combinational multiply-and-reduce with ports a[N-1:0], b[N-1:0], p[N:0], s[N-1:0].
  - Instantiated once in gf_matvec_seq.
  - Unit-tested standalone.
- Counters, FSM and the result register file stay in the top module.

Test Plan:
- gf_mult_comb, N=8, p=0x11B:
  - 0x57·0x83 → 0xC1;
  - 0x53·0xCA → 0x01;
  - 0x00·0xFF → 0x00;
  - 0x01·0xAB → 0xAB.
- N=8, ROWS=COLS=2, p=0x11B, A=[[0x57,0x00],[0x00,0x53]], b=[0x83,0xCA], accumulate=0:
  - s=[0xC1,0x01];
  - out_valid rises 4 cycles after accept;
  - busy high for exactly 4 cycles.
- Repeat the same job with accumulate=1 → s=[0x00,0x00]. Repeat once more with accumulate=1 → s=[0xC1,0x01].
- N=4, ROWS=COLS=1, p=0x13, A=[0x8], b=[0x2] → s=0x3, out_valid 1 cycle after accept.
- Backpressure and input blocking:
  - Hold out_ready=0 for 10 cycles in DONE: out_valid and s_flat stay stable.
  - in_valid=1 throughout: no second accept until 1 cycle after out_ready.
- Assert rst_n=0 for one cycle mid-RUN:
  - next cycle: IDLE, in_ready=1, out_valid=0, s_flat=0.
  - A fresh job then completes with correct values and nominal latency.
